fetch_queue: RTL

//  Instruction buffer between the fetch/PC stage and decode. Accepts fetch packets
//  {pc, inst, epoch, pred_taken, pred_target} over a valid/ready handshake and stores

---
 rtl/fetch_pkg.sv | 14 +
 rtl/fetch_queue.sv | 110 +++++++++++
 2 files changed

// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - fetch packet type and epoch width shared by the fetch queue
package fetch_pkg;

  localparam int FETCH_EPOCH_W = 3;

  typedef struct packed {
    logic [31:0]              pc;
    logic [31:0]              inst;
    logic [FETCH_EPOCH_W-1:0] epoch;
    logic                     pred_taken;
    logic [31:0]              pred_target;
  } fetch_pkt_t;

endpackage

// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - in-order fetch-to-decode buffer with epoch filtering and redirect flush
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int EPOCH_W = FETCH_EPOCH_W
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [31:0]              in_pc,
  input  logic [31:0]              in_inst,
  input  logic [EPOCH_W-1:0]       in_epoch,
  input  logic                     in_pred_taken,
  input  logic [31:0]              in_pred_target,
  input  logic                     redirect_valid,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [31:0]              out_pc,
  output logic [31:0]              out_inst,
  output logic [EPOCH_W-1:0]       out_epoch,
  output logic                     out_pred_taken,
  output logic [31:0]              out_pred_target,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  fetch_pkt_t         mem_q [DEPTH];
  logic [PW-1:0]      head_q, head_d, tail_q, tail_d;
  logic [CW-1:0]      count_q, count_d;
  logic [EPOCH_W-1:0] epoch_q, epoch_d;

  logic       stale, full, empty, enq, deq;
  fetch_pkt_t in_pkt, head_pkt;

  assign stale = (in_epoch != epoch_q);
  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);

  // A stale packet is always swallowed so the fetch stage never stalls on dead work.
  assign in_ready  = !full || stale;
  assign enq       = in_valid && in_ready && !stale && !redirect_valid;
  assign out_valid = !empty && !redirect_valid;
  assign deq       = out_valid && out_ready;

  always_comb begin
    in_pkt             = '0;
    in_pkt.pc          = in_pc;
    in_pkt.inst        = in_inst;
    in_pkt.epoch       = in_epoch;
    in_pkt.pred_taken  = in_pred_taken;
    in_pkt.pred_target = in_pred_target;
  end

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    epoch_d = epoch_q;
    if (redirect_valid) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
      epoch_d = epoch_q + EPOCH_W'(1);
    end else begin
      if (enq) tail_d = tail_q + PW'(1);
      if (deq) head_d = head_q + PW'(1);
      case ({enq, deq})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      epoch_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      epoch_q <= epoch_d;
    end
  end

  // Entries are never cleared; occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    if (enq) mem_q[tail_q] <= in_pkt;
  end

  always_comb begin
    head_pkt = '0;
    if (!empty) head_pkt = mem_q[head_q];
  end

  assign out_pc          = head_pkt.pc;
  assign out_inst        = head_pkt.inst;
  assign out_epoch       = head_pkt.epoch;
  assign out_pred_taken  = head_pkt.pred_taken;
  assign out_pred_target = head_pkt.pred_target;
  assign count           = count_q;

endmodule
